// File: rtl/pe_gen.sv
// Systolic-array processing element: weight x activation multiply folded into a carry-save partial-sum pair.
// Optional build macro PE_GEN_ZERO_SKIP_EN gates multiplier operands on zero and adds a skip_cnt output.
module pe_gen #(
  parameter int DW   = 8,
  parameter int SIZE = 4,
  parameter int PSW  = $clog2(SIZE) + 2*DW
) (
  input  logic            clk,
  input  logic            rst_n,
  // in_valid qualifies in/psum0_i/psum1_i for one cycle; there is no ready, every valid cycle is consumed.
  input  logic            in_valid,
  input  logic [DW-1:0]   in,
  input  logic [PSW-1:0]  psum0_i,
  input  logic [PSW-1:0]  psum1_i,
  input  logic [DW-1:0]   w_in,
  input  logic            w_load,
  input  logic            w_swap,
  input  logic            signed_mode,
  input  logic            acc_mode,
  input  logic            acc_clr,
  output logic            valid_o,
  output logic [DW-1:0]   in_o,
  output logic [PSW-1:0]  psum0_o,
  output logic [PSW-1:0]  psum1_o,
  output logic [DW-1:0]   w_o
`ifdef PE_GEN_ZERO_SKIP_EN
  ,
  output logic [15:0]     skip_cnt
`endif
);

  logic [DW-1:0]  shadow_q, shadow_d;
  logic [DW-1:0]  active_q, active_d;
  logic [DW-1:0]  in_q, in_d;
  logic [PSW-1:0] psum0_q, psum0_d;
  logic [PSW-1:0] psum1_q, psum1_d;
  logic           valid_q, valid_d;

  logic [DW-1:0]         mul_w, mul_x;
  logic [2*DW+1:0]       a_w, b_w;
  logic signed [2*DW+1:0] prod_s;
  logic [PSW-1:0]        p;
  logic [PSW-1:0]        op_a, op_b;
  logic [PSW-1:0]        sum_bits, maj_bits;

`ifdef PE_GEN_ZERO_SKIP_EN
  logic        skip;
  logic [15:0] skip_cnt_q, skip_cnt_d;

  // Zero operands are isolated so the multiplier inputs stay quiet; the product is 0 either way.
  always_comb begin
    skip  = (in == '0) || (active_q == '0);
    mul_w = skip ? '0 : active_q;
    mul_x = skip ? '0 : in;
  end
`else
  always_comb begin
    mul_w = active_q;
    mul_x = in;
  end
`endif

  // One guard bit per operand makes a single modular multiply serve both signed and unsigned modes.
  always_comb begin
    a_w    = {{(DW+2){signed_mode & mul_w[DW-1]}}, mul_w};
    b_w    = {{(DW+2){signed_mode & mul_x[DW-1]}}, mul_x};
    prod_s = a_w * b_w;
    p      = PSW'(prod_s);
  end

  always_comb begin
    op_a     = acc_mode ? psum0_q : psum0_i;
    op_b     = acc_mode ? psum1_q : psum1_i;
    sum_bits = op_a ^ op_b ^ p;
    maj_bits = (op_a & op_b) | (op_a & p) | (op_b & p);
  end

  always_comb begin
    valid_d  = in_valid;
    in_d     = in_q;
    psum0_d  = psum0_q;
    psum1_d  = psum1_q;
    shadow_d = shadow_q;
    active_d = active_q;
    if (in_valid) begin
      in_d    = in;
      psum0_d = sum_bits;
      psum1_d = {maj_bits[PSW-2:0], 1'b0};
    end
    if (acc_clr) begin
      psum0_d = '0;
      psum1_d = '0;
    end
    // Swap reads the pre-edge shadow, so load+swap together moves the old shadow into active.
    if (w_load) shadow_d = w_in;
    if (w_swap) active_d = shadow_q;
  end

`ifdef PE_GEN_ZERO_SKIP_EN
  always_comb begin
    skip_cnt_d = skip_cnt_q;
    if (in_valid && skip) skip_cnt_d = skip_cnt_q + 16'd1;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
      active_q <= '0;
      in_q     <= '0;
      psum0_q  <= '0;
      psum1_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      in_q     <= in_d;
      psum0_q  <= psum0_d;
      psum1_q  <= psum1_d;
      valid_q  <= valid_d;
    end
  end

`ifdef PE_GEN_ZERO_SKIP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) skip_cnt_q <= '0;
    else        skip_cnt_q <= skip_cnt_d;
  end
  assign skip_cnt = skip_cnt_q;
`endif

  assign valid_o = valid_q;
  assign in_o    = in_q;
  assign psum0_o = psum0_q;
  assign psum1_o = psum1_q;
  assign w_o     = shadow_q;

endmodule

// File: tb/tb_pe_gen.sv
// Bench for pe_gen: directed scenarios plus random traffic against a sum-level arithmetic model.
module tb_pe_gen;
  localparam int DW   = 8;
  localparam int SIZE = 4;
  localparam int PSW  = 18;
  localparam longint MASK = (longint'(1) << PSW) - 1;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic [DW-1:0]  x_in = '0;
  logic [PSW-1:0] psum0_i = '0, psum1_i = '0;
  logic [DW-1:0]  w_in = '0;
  logic           w_load = 1'b0, w_swap = 1'b0;
  logic           signed_mode = 1'b0, acc_mode = 1'b0, acc_clr = 1'b0;
  logic           valid_o;
  logic [DW-1:0]  in_o, w_o;
  logic [PSW-1:0] psum0_o, psum1_o;
`ifdef PE_GEN_ZERO_SKIP_EN
  logic [15:0]    skip_cnt;
`endif

  pe_gen #(.DW(DW), .SIZE(SIZE), .PSW(PSW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in(x_in),
    .psum0_i(psum0_i), .psum1_i(psum1_i), .w_in(w_in), .w_load(w_load), .w_swap(w_swap),
    .signed_mode(signed_mode), .acc_mode(acc_mode), .acc_clr(acc_clr),
    .valid_o(valid_o), .in_o(in_o), .psum0_o(psum0_o), .psum1_o(psum1_o), .w_o(w_o)
`ifdef PE_GEN_ZERO_SKIP_EN
    , .skip_cnt(skip_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Reference state: only the arithmetic sum of the psum pair is modelled.
  longint    sum_m, in_m, shadow_m, act_m, valid_m, skip_m;
  int        n_vec = 0, n_err = 0;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint to_int(input logic [DW-1:0] v, input logic sm);
    longint r;
    r = longint'(v);
    if (sm && v[DW-1]) r = r - (longint'(1) << DW);
    return r;
  endfunction

  function automatic longint obs_sum();
    logic [PSW-1:0] s;
    s = psum0_o + psum1_o;
    return longint'(s);
  endfunction

  task automatic model_reset();
    sum_m = 0; in_m = 0; shadow_m = 0; act_m = 0; valid_m = 0; skip_m = 0;
  endtask

  task automatic idle_ctrl();
    in_valid = 0; w_load = 0; w_swap = 0; acc_clr = 0;
  endtask

  task automatic step();
    longint p, base;
    p = to_int(DW'(act_m), signed_mode) * to_int(x_in, signed_mode);
    if (in_valid && (x_in == 0 || act_m == 0)) skip_m = (skip_m + 1) & 16'hFFFF;
    if (acc_clr) sum_m = 0;
    else if (in_valid) begin
      base  = acc_mode ? sum_m : longint'(psum0_i) + longint'(psum1_i);
      sum_m = (base + p) & MASK;
    end
    valid_m = in_valid;
    if (in_valid) in_m = x_in;
    if (w_swap) act_m = shadow_m;
    if (w_load) shadow_m = w_in;
    @(posedge clk);
    #1;
    chk("valid_o", valid_o, valid_m);
    chk("in_o", in_o, in_m);
    chk("psum_sum", obs_sum(), sum_m);
    chk("w_o", w_o, shadow_m);
    chk("psum1_lsb", psum1_o[0], 0);
`ifdef PE_GEN_ZERO_SKIP_EN
    chk("skip_cnt", skip_cnt, skip_m);
`endif
  endtask

  task automatic set_weight(input logic [DW-1:0] w);
    idle_ctrl(); w_in = w; w_load = 1; step();
    w_load = 0; w_swap = 1; step();
    w_swap = 0;
  endtask

  task automatic acc_start();
    idle_ctrl(); acc_mode = 1; acc_clr = 1; step();
    acc_clr = 0;
  endtask

  initial begin
    longint skip0;
    model_reset();
    #12;
    chk("rst_valid", valid_o, 0);
    chk("rst_in_o", in_o, 0);
    chk("rst_psum0", psum0_o, 0);
    chk("rst_psum1", psum1_o, 0);
    chk("rst_w_o", w_o, 0);
    @(negedge clk); rst_n = 1;

    // Basic pass-through with upstream psum
    set_weight(3);
    x_in = 5; psum0_i = 10; psum1_i = 0; acc_mode = 0; in_valid = 1; step();
    chk("basic_sum", obs_sum(), 25);
    chk("basic_in_o", in_o, 5);
    idle_ctrl(); step();
    chk("hold_sum", obs_sum(), 25);

    // Signed vs unsigned interpretation of the same bits
    set_weight(8'hFE);
    psum0_i = 0; psum1_i = 0; x_in = 8'h7F; signed_mode = 1; in_valid = 1; step();
    chk("signed_sum", obs_sum(), 261890);
    signed_mode = 0; step();
    chk("unsigned_sum", obs_sum(), 32258);

    // Output-stationary accumulation and clear
    set_weight(3);
    acc_start();
    x_in = 1; in_valid = 1;
    repeat (4) step();
    chk("acc_sum", obs_sum(), 12);
    in_valid = 0; acc_clr = 1; step();
    chk("clr_psum0", psum0_o, 0);
    chk("clr_psum1", psum1_o, 0);
    acc_clr = 0; acc_mode = 0;

    // Load and swap in the same cycle as a valid operand
    set_weight(2);
    idle_ctrl(); w_in = 7; w_load = 1; step();
    w_in = 9; w_load = 1; w_swap = 1; x_in = 1; in_valid = 1; step();
    chk("swap_prod", obs_sum(), 2);
    chk("swap_w_o", w_o, 9);
    idle_ctrl(); x_in = 1; in_valid = 1; step();
    chk("swap_active", obs_sum(), 7);

    // Asynchronous reset mid-accumulation
    set_weight(3);
    acc_start();
    x_in = 1; in_valid = 1;
    repeat (4) step();
    chk("pre_rst_sum", obs_sum(), 12);
    idle_ctrl();
    rst_n = 0;
    #2;
    chk("arst_valid", valid_o, 0);
    chk("arst_in_o", in_o, 0);
    chk("arst_psum0", psum0_o, 0);
    chk("arst_psum1", psum1_o, 0);
    chk("arst_w_o", w_o, 0);
    model_reset();
    @(negedge clk); rst_n = 1;
    acc_mode = 1; x_in = 5; in_valid = 1; step();
    chk("post_rst_sum", obs_sum(), 0);
    idle_ctrl();

    // Zero operands feeding an accumulation
    set_weight(2);
    acc_start();
    skip0 = skip_m;
    x_in = 0; in_valid = 1;
    repeat (3) step();
    x_in = 4; step();
    chk("zero_sum", obs_sum(), 8);
    chk("zero_skips", skip_m - skip0, 3);
    idle_ctrl(); acc_mode = 0;

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      in_valid    = ($urandom_range(0, 3) != 0);
      x_in        = ($urandom_range(0, 7) == 0) ? '0 : DW'($urandom);
      psum0_i     = PSW'($urandom);
      psum1_i     = PSW'($urandom);
      w_in        = ($urandom_range(0, 7) == 0) ? '0 : DW'($urandom);
      w_load      = ($urandom_range(0, 3) == 0);
      w_swap      = ($urandom_range(0, 3) == 0);
      signed_mode = 1'($urandom);
      acc_mode    = ($urandom_range(0, 2) != 0);
      acc_clr     = ($urandom_range(0, 15) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
